// File: rtl/ref_window_loader.sv
// ============================================================================
// Module   : ref_window_loader
// Brief    : Collects a raster-order WIN x WIN reference window, then streams
//            it out one row per beat (optionally followed by one column per beat).
// Option   : REF_WIN_LOADER_TRANSPOSE_EN adds the column (transpose) pass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ref_window_loader #(
   parameter int NUM_PIXEL = 8,
   parameter int PIX_W     = 8,
   parameter int IDX_W     = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [PIX_W-1:0]                 in_pixel,
   input  logic                             in_sof,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [(NUM_PIXEL+7)*PIX_W-1:0]   out_row,
   output logic [IDX_W-1:0]                 out_idx,
   output logic                             out_col,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_last,
   output logic                             win_done,
   output logic                             sof_err,
   output logic                             busy
);

   localparam int WIN = NUM_PIXEL + 7;
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WIN - 1);
   localparam logic [IDX_W-1:0] c_PENULT   = IDX_W'(WIN - 2);
   localparam logic [IDX_W-1:0] c_ONE      = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_ROWS = 2'd2
`ifdef REF_WIN_LOADER_TRANSPOSE_EN
      , ST_COLS = 2'd3
`endif
   } state_t;

   state_t              r_state;
   logic [PIX_W-1:0]    r_win [WIN][WIN];
   logic [IDX_W-1:0]    r_row;
   logic [IDX_W-1:0]    r_col;
   logic [IDX_W-1:0]    r_out_idx;
   logic                r_out_valid;
   logic                r_out_last;
   logic                r_win_done;
   logic                r_sof_err;
   logic                r_in_ready;

   logic                      w_in_xfer;
   logic                      w_out_xfer;
   logic                      w_store;
   logic [IDX_W-1:0]          w_wr_row;
   logic [IDX_W-1:0]          w_wr_col;
   logic [WIN*PIX_W-1:0]      w_row_data;

   assign w_in_xfer  = in_valid && r_in_ready;
   assign w_out_xfer = r_out_valid && out_ready;
   // A start-of-frame pixel always lands at [0][0], whether starting or restarting
   assign w_store    = w_in_xfer && (in_sof || (r_state == ST_FILL));
   assign w_wr_row   = in_sof ? '0 : r_row;
   assign w_wr_col   = in_sof ? '0 : r_col;

   always_ff @(posedge clock) begin
      if (w_store) begin
         r_win[w_wr_row][w_wr_col] <= in_pixel;
      end
   end

`ifdef REF_WIN_LOADER_TRANSPOSE_EN
   logic                 r_out_col;
   logic [WIN*PIX_W-1:0] w_col_data;
`endif

   generate
      for (genvar c = 0; c < WIN; c++) begin : g_elem
         assign w_row_data[c*PIX_W +: PIX_W] = r_win[r_out_idx][c];
`ifdef REF_WIN_LOADER_TRANSPOSE_EN
         assign w_col_data[c*PIX_W +: PIX_W] = r_win[c][r_out_idx];
`endif
      end
   endgenerate

`ifdef REF_WIN_LOADER_TRANSPOSE_EN
   assign out_row = r_out_col ? w_col_data : w_row_data;
   assign out_col = r_out_col;
`else
   assign out_row = w_row_data;
   assign out_col = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_win_done  <= 1'b0;
         r_sof_err   <= 1'b0;
         r_in_ready  <= 1'b1;
`ifdef REF_WIN_LOADER_TRANSPOSE_EN
         r_out_col   <= 1'b0;
`endif
      end else begin
         r_win_done <= 1'b0;
         r_sof_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_in_xfer && in_sof) begin
                  r_row   <= '0;
                  r_col   <= c_ONE;
                  r_state <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (w_in_xfer) begin
                  if (in_sof) begin
                     r_sof_err <= 1'b1;
                     r_row     <= '0;
                     r_col     <= c_ONE;
                  end else if (r_col == c_LAST_IDX) begin
                     r_col <= '0;
                     if (r_row == c_LAST_IDX) begin
                        r_row       <= '0;
                        r_state     <= ST_ROWS;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_idx   <= '0;
                        r_out_last  <= 1'b0;
                     end else begin
                        r_row <= r_row + c_ONE;
                     end
                  end else begin
                     r_col <= r_col + c_ONE;
                  end
               end
            end
            ST_ROWS: begin
               if (w_out_xfer) begin
                  if (r_out_idx == c_LAST_IDX) begin
                     r_out_idx  <= '0;
                     r_out_last <= 1'b0;
`ifdef REF_WIN_LOADER_TRANSPOSE_EN
                     r_state    <= ST_COLS;
                     r_out_col  <= 1'b1;
`else
                     r_state     <= ST_IDLE;
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_win_done  <= 1'b1;
`endif
                  end else begin
                     r_out_idx <= r_out_idx + c_ONE;
`ifdef REF_WIN_LOADER_TRANSPOSE_EN
                     r_out_last <= 1'b0;
`else
                     r_out_last <= (r_out_idx == c_PENULT);
`endif
                  end
               end
            end
`ifdef REF_WIN_LOADER_TRANSPOSE_EN
            ST_COLS: begin
               if (w_out_xfer) begin
                  if (r_out_idx == c_LAST_IDX) begin
                     r_out_idx   <= '0;
                     r_out_last  <= 1'b0;
                     r_out_col   <= 1'b0;
                     r_state     <= ST_IDLE;
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_win_done  <= 1'b1;
                  end else begin
                     r_out_idx  <= r_out_idx + c_ONE;
                     r_out_last <= (r_out_idx == c_PENULT);
                  end
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_idx   = r_out_idx;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign win_done  = r_win_done;
   assign sof_err   = r_sof_err;
   assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
